// File: rtl/hls_deadlock_pkg.sv
// Shared defaults and helpers for the per-process HLS deadlock monitors.
// Every monitor instance imports this package so masks and widths stay consistent.
package hls_deadlock_pkg;

  localparam int DEF_N_AXIS   = 4;
  localparam int DEF_N_INST   = 7;
  localparam int DEF_THRESH_W = 16;
  localparam int DEF_EVT_W    = 8;
  localparam int SRC_MAX_W    = 64;

  localparam logic [DEF_N_AXIS-1:0] DEF_AXIS_MASK = 4'b0011;
  localparam logic [DEF_N_INST-1:0] DEF_INST_MASK = '0;

  // Packs {inst_hit, axis_hit}; callers truncate the result to N_AXIS+N_INST bits.
  function automatic logic [SRC_MAX_W-1:0] build_src(
    input logic [31:0] inst_hit,
    input logic [31:0] axis_hit,
    input int unsigned n_axis
  );
    build_src = ({32'd0, inst_hit} << n_axis) | {32'd0, axis_hit};
  endfunction

endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// Saturating run-length counter: counts consecutive enabled cycles up to the
// effective threshold and flags the cycle that completes the run.
module hls_deadlock_persist_cnt
  import hls_deadlock_pkg::*;
#(
  parameter int THRESH_W = DEF_THRESH_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                enable,
  input  logic [THRESH_W-1:0] threshold,
  output logic                hit
);

  logic [THRESH_W-1:0] persist_cnt;
  logic [THRESH_W-1:0] thr_eff;
  logic [THRESH_W:0]   cnt_inc;
  logic                reach;

  // A zero threshold behaves like one so the flag can never fire without a stall.
  assign thr_eff = (threshold == '0) ? THRESH_W'(1) : threshold;
  assign cnt_inc = {1'b0, persist_cnt} + {{THRESH_W{1'b0}}, 1'b1};
  assign reach   = cnt_inc >= {1'b0, thr_eff};
  assign hit     = enable & reach;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      persist_cnt <= '0;
    end else if (clear || !enable) begin
      persist_cnt <= '0;
    end else if (reach) begin
      persist_cnt <= thr_eff;
    end else begin
      persist_cnt <= cnt_inc[THRESH_W-1:0];
    end
  end

endmodule

// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor for one HLS dataflow process: raises block once a masked
// stall persists for the runtime threshold, snapshots its sources, counts events.
module hls_deadlock_persist_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int                N_AXIS    = DEF_N_AXIS,
  parameter int                N_INST    = DEF_N_INST,
  parameter logic [N_AXIS-1:0] AXIS_MASK = N_AXIS'(DEF_AXIS_MASK),
  parameter logic [N_INST-1:0] INST_MASK = N_INST'(DEF_INST_MASK),
  parameter int                THRESH_W  = DEF_THRESH_W,
  parameter int                EVT_W     = DEF_EVT_W,
  parameter bit                STICKY    = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_AXIS-1:0]        axis_block_sigs,
  input  logic [N_INST-1:0]        inst_idle_sigs,
  input  logic [N_INST-1:0]        inst_block_sigs,
  input  logic [THRESH_W-1:0]      threshold,
  input  logic                     clear,
  output logic                     block,
  output logic [N_AXIS+N_INST-1:0] block_src,
  output logic [EVT_W-1:0]         block_evt_cnt
);

  localparam int SRC_W = N_AXIS + N_INST;

  logic [N_AXIS-1:0] axis_hit;
  logic [N_INST-1:0] inst_hit;
  logic [SRC_W-1:0]  src_now;
  logic              cond;
  logic              hit;
  logic              block_nxt;
  logic              block_rise;

  // An instance only counts as stalled when it is blocked and not idle.
  assign axis_hit = axis_block_sigs & AXIS_MASK;
  assign inst_hit = inst_block_sigs & ~inst_idle_sigs & INST_MASK;
  assign cond     = (|axis_hit) | (|inst_hit);
  assign src_now  = SRC_W'(build_src(32'(inst_hit), 32'(axis_hit), N_AXIS));

  hls_deadlock_persist_cnt #(
    .THRESH_W (THRESH_W)
  ) u_persist_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .enable    (cond),
    .threshold (threshold),
    .hit       (hit)
  );

  assign block_nxt  = STICKY ? (block | hit) : hit;
  assign block_rise = block_nxt & ~block;

  // Clear outranks every other update, including a rising edge in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      block         <= 1'b0;
      block_src     <= '0;
      block_evt_cnt <= '0;
    end else if (clear) begin
      block         <= 1'b0;
      block_src     <= '0;
      block_evt_cnt <= '0;
    end else begin
      block <= block_nxt;
      if (block_rise) begin
        block_src <= src_now;
        if (block_evt_cnt != '1) begin
          block_evt_cnt <= block_evt_cnt + EVT_W'(1);
        end
      end
    end
  end

endmodule
